// File: rtl/axil_stream_regs.sv
// AXI4-Lite slave exposing NUM_WR outbound and NUM_RD inbound
// valid/ready channels behind a flat word-addressed register window.
module axil_stream_regs #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int NUM_WR = 4,
   parameter int NUM_RD = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_W-1:0]        s_awaddr,
   input  logic                     s_awvalid,
   output logic                     s_awready,
   input  logic [DATA_W-1:0]        s_wdata,
   input  logic [3:0]               s_wstrb,
   input  logic                     s_wvalid,
   output logic                     s_wready,
   output logic [1:0]               s_bresp,
   output logic                     s_bvalid,
   input  logic                     s_bready,
   input  logic [ADDR_W-1:0]        s_araddr,
   input  logic                     s_arvalid,
   output logic                     s_arready,
   output logic [DATA_W-1:0]        s_rdata,
   output logic [1:0]               s_rresp,
   output logic                     s_rvalid,
   input  logic                     s_rready,
   output logic [NUM_WR*DATA_W-1:0] wr_tdata,
   output logic [NUM_WR-1:0]        wr_tvalid,
   input  logic [NUM_WR-1:0]        wr_tready,
   input  logic [NUM_RD*DATA_W-1:0] rd_tdata,
   input  logic [NUM_RD-1:0]        rd_tvalid,
   output logic [NUM_RD-1:0]        rd_tready
);
   localparam int WW = ADDR_W - 2;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_NEED_W, W_NEED_AW, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t          w_state;
   r_state_t          r_state;
   logic [WW-1:0]     aw_q;
   logic [DATA_W-1:0] wd_q;
   logic [3:0]        ws_q;
   logic [DATA_W-1:0] shadow [NUM_WR];

   logic              aw_hs;
   logic              w_hs;
   logic              commit;
   logic [WW-1:0]     c_word;
   logic [DATA_W-1:0] c_data;
   logic [3:0]        c_strb;
   logic [NUM_WR-1:0] c_hit;

   logic [WW-1:0]     r_word;
   logic [DATA_W-1:0] status;
   logic [DATA_W-1:0] r_data_n;
   logic [1:0]        r_resp_n;
   logic [NUM_RD-1:0] r_pop;

   logic              unused_addr_bits;
   assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

   function automatic logic [DATA_W-1:0] merge(
      input logic [DATA_W-1:0] old,
      input logic [DATA_W-1:0] d,
      input logic [3:0]        st
   );
      merge = old;
      for (int b = 0; b < 4; b++)
         if (st[b]) merge[8*b +: 8] = d[8*b +: 8];
   endfunction

   assign aw_hs = s_awvalid && s_awready;
   assign w_hs  = s_wvalid && s_wready;

   // Commit uses whichever half arrived earlier from its capture register
   always_comb begin
      commit = 1'b0;
      c_word = s_awaddr[ADDR_W-1:2];
      c_data = s_wdata;
      c_strb = s_wstrb;
      unique case (w_state)
         W_IDLE:    commit = aw_hs && w_hs;
         W_NEED_W: begin
            commit = w_hs;
            c_word = aw_q;
         end
         W_NEED_AW: begin
            commit = aw_hs;
            c_data = wd_q;
            c_strb = ws_q;
         end
         default:   commit = 1'b0;
      endcase
      c_hit = '0;
      for (int k = 0; k < NUM_WR; k++)
         c_hit[k] = (32'(c_word) == k + 1) && wr_tready[k];
   end

   always_comb begin
      for (int k = 0; k < NUM_WR; k++)
         wr_tdata[DATA_W*k +: DATA_W] = shadow[k];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_state   <= W_IDLE;
         s_awready <= 1'b1;
         s_wready  <= 1'b1;
         s_bvalid  <= 1'b0;
         s_bresp   <= OKAY;
         aw_q      <= '0;
         wd_q      <= '0;
         ws_q      <= '0;
         wr_tvalid <= '0;
         for (int k = 0; k < NUM_WR; k++) shadow[k] <= '0;
      end else begin
         wr_tvalid <= '0;
         if (commit) begin
            w_state   <= W_RESP;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b1;
            s_bresp   <= (|c_hit) ? OKAY : SLVERR;
            for (int k = 0; k < NUM_WR; k++) begin
               if (c_hit[k]) begin
                  shadow[k]    <= merge(shadow[k], c_data, c_strb);
                  wr_tvalid[k] <= 1'b1;
               end
            end
         end else begin
            unique case (w_state)
               W_IDLE: begin
                  if (aw_hs) begin
                     aw_q      <= s_awaddr[ADDR_W-1:2];
                     s_awready <= 1'b0;
                     w_state   <= W_NEED_W;
                  end else if (w_hs) begin
                     wd_q     <= s_wdata;
                     ws_q     <= s_wstrb;
                     s_wready <= 1'b0;
                     w_state  <= W_NEED_AW;
                  end
               end
               W_RESP: begin
                  if (s_bready) begin
                     s_bvalid  <= 1'b0;
                     s_awready <= 1'b1;
                     s_wready  <= 1'b1;
                     w_state   <= W_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      status = '0;
      status[NUM_WR-1:0] = wr_tready;
      status[NUM_WR+NUM_RD-1:NUM_WR] = rd_tvalid;
      r_word   = s_araddr[ADDR_W-1:2];
      r_data_n = '0;
      r_resp_n = SLVERR;
      r_pop    = '0;
      if (r_word == '0) begin
         r_data_n = status;
         r_resp_n = OKAY;
      end
      for (int k = 0; k < NUM_RD; k++) begin
         if ((32'(r_word) == NUM_WR + 1 + k) && rd_tvalid[k]) begin
            r_data_n = rd_tdata[DATA_W*k +: DATA_W];
            r_resp_n = OKAY;
            r_pop[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= R_IDLE;
         s_arready <= 1'b1;
         s_rvalid  <= 1'b0;
         s_rdata   <= '0;
         s_rresp   <= OKAY;
         rd_tready <= '0;
      end else begin
         rd_tready <= '0;
         unique case (r_state)
            R_IDLE: begin
               if (s_arvalid) begin
                  s_rdata   <= r_data_n;
                  s_rresp   <= r_resp_n;
                  rd_tready <= r_pop;
                  s_rvalid  <= 1'b1;
                  s_arready <= 1'b0;
                  r_state   <= R_DATA;
               end
            end
            R_DATA: begin
               if (s_rready) begin
                  s_rvalid  <= 1'b0;
                  s_arready <= 1'b1;
                  r_state   <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_stream_regs.sv
// Scoreboard bench for axil_stream_regs: directed AXI-Lite traffic,
// expected responses queued at issue and popped by output monitors.
module tb_axil_stream_regs;
   localparam int AW = 8;
   localparam int NW = 4;
   localparam int NR = 4;
   localparam logic [1:0] OK = 2'b00;
   localparam logic [1:0] SE = 2'b10;

   logic            clk = 1'b0;
   logic            reset;
   logic [AW-1:0]   s_awaddr;
   logic            s_awvalid;
   logic            s_awready;
   logic [31:0]     s_wdata;
   logic [3:0]      s_wstrb;
   logic            s_wvalid;
   logic            s_wready;
   logic [1:0]      s_bresp;
   logic            s_bvalid;
   logic            s_bready;
   logic [AW-1:0]   s_araddr;
   logic            s_arvalid;
   logic            s_arready;
   logic [31:0]     s_rdata;
   logic [1:0]      s_rresp;
   logic            s_rvalid;
   logic            s_rready;
   logic [NW*32-1:0] wr_tdata;
   logic [NW-1:0]   wr_tvalid;
   logic [NW-1:0]   wr_tready;
   logic [NR*32-1:0] rd_tdata;
   logic [NR-1:0]   rd_tvalid;
   logic [NR-1:0]   rd_tready;

   int checks = 0;
   int errors = 0;
   int bv_cycles = 0;

   logic [1:0]  exp_b[$];
   logic [33:0] exp_r[$];
   logic [35:0] exp_wr[$];
   int          exp_pop[$];

   always #5 clk = ~clk;

   axil_stream_regs #(
      .ADDR_W(AW), .DATA_W(32), .NUM_WR(NW), .NUM_RD(NR)
   ) dut (
      .clk(clk), .reset(reset),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
      .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
      .s_bready(s_bready), .s_araddr(s_araddr), .s_arvalid(s_arvalid),
      .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .wr_tdata(wr_tdata), .wr_tvalid(wr_tvalid), .wr_tready(wr_tready),
      .rd_tdata(rd_tdata), .rd_tvalid(rd_tvalid), .rd_tready(rd_tready)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s: unexpected DUT output", name);
   endtask

   // Monitors: pop the scoreboard whenever the DUT presents an output
   always @(negedge clk) begin
      if (!reset) begin
         if (s_bvalid) bv_cycles++;
         if (s_bvalid && s_bready) begin
            if (exp_b.size() == 0) flag("bresp_extra");
            else chk("bresp", s_bresp, exp_b.pop_front());
         end
         if (s_rvalid && s_rready) begin
            if (exp_r.size() == 0) flag("rdata_extra");
            else begin
               logic [33:0] e;
               e = exp_r.pop_front();
               chk("rdata", s_rdata, e[31:0]);
               chk("rresp", s_rresp, e[33:32]);
            end
         end
         for (int k = 0; k < NW; k++) begin
            if (wr_tvalid[k]) begin
               if (exp_wr.size() == 0) flag("wr_tvalid_extra");
               else begin
                  logic [35:0] e;
                  e = exp_wr.pop_front();
                  chk("wr_channel", k, e[35:32]);
                  chk("wr_tdata", wr_tdata[32*k +: 32], e[31:0]);
               end
            end
         end
         for (int k = 0; k < NR; k++) begin
            if (rd_tready[k]) begin
               if (exp_pop.size() == 0) flag("rd_tready_extra");
               else chk("rd_pop_channel", k, exp_pop.pop_front());
            end
         end
      end
   end

   function automatic logic sig_of(input int which);
      case (which)
         0: return s_awready;
         1: return s_wready;
         2: return s_arready;
         3: return s_bvalid;
         default: return s_rvalid;
      endcase
   endfunction

   task automatic wait_hi(input int which);
      int t = 0;
      while (!sig_of(which) && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 100) flag($sformatf("timeout_%0d", which));
   endtask

   task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] st, input logic [1:0] resp,
                            input int wch, input logic [31:0] wexp,
                            input int w_lead, input int b_delay);
      exp_b.push_back(resp);
      if (wch >= 0) exp_wr.push_back({4'(wch), wexp});
      s_bready = 1'b0;
      fork
         begin
            repeat (w_lead) begin @(posedge clk); #1; end
            s_awaddr = a;
            s_awvalid = 1'b1;
            wait_hi(0);
            @(posedge clk); #1;
            s_awvalid = 1'b0;
         end
         begin
            s_wdata = d;
            s_wstrb = st;
            s_wvalid = 1'b1;
            wait_hi(1);
            @(posedge clk); #1;
            s_wvalid = 1'b0;
         end
      join
      wait_hi(3);
      repeat (b_delay) begin @(posedge clk); #1; end
      s_bready = 1'b1;
      @(posedge clk); #1;
      s_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [7:0] a, input logic [31:0] d,
                           input logic [1:0] resp, input int pop_ch);
      exp_r.push_back({resp, d});
      if (pop_ch >= 0) exp_pop.push_back(pop_ch);
      s_rready = 1'b1;
      s_araddr = a;
      s_arvalid = 1'b1;
      wait_hi(2);
      @(posedge clk); #1;
      s_arvalid = 1'b0;
      wait_hi(4);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      s_awaddr = '0; s_awvalid = 1'b0;
      s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
      s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b1;
      wr_tready = '1; rd_tvalid = '0; rd_tdata = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      chk("rst_ready", {s_awready, s_wready, s_arready}, 3'b111);
      chk("rst_valid", {s_bvalid, s_rvalid}, 2'b00);
      chk("rst_resp", {s_bresp, s_rresp}, 4'h0);
      chk("rst_rdata", s_rdata, 0);
      chk("rst_pulses", {wr_tvalid, rd_tready}, 8'h00);
      chk("rst_shadow", wr_tdata[63:0], 64'h0);

      axi_write(8'h04, 32'hDEADBEEF, 4'hF, OK, 0, 32'hDEADBEEF, 0, 0);
      axi_write(8'h04, 32'h00001234, 4'h3, OK, 0, 32'hDEAD1234, 0, 0);
      chk("wr0_hold", wr_tdata[31:0], 32'hDEAD1234);

      bv_cycles = 0;
      axi_write(8'h0C, 32'h12345678, 4'hF, OK, 2, 32'h12345678, 3, 5);
      chk("bvalid_cycles", bv_cycles, 6);

      axi_write(8'hFC, 32'h11111111, 4'hF, SE, -1, 0, 0, 0);
      wr_tready[1] = 1'b0;
      axi_write(8'h08, 32'h22222222, 4'hF, SE, -1, 0, 0, 0);
      wr_tready[1] = 1'b1;
      axi_write(8'h14, 32'h33333333, 4'hF, SE, -1, 0, 0, 0);
      axi_write(8'h00, 32'h44444444, 4'hF, SE, -1, 0, 0, 0);
      chk("wr1_unchanged", wr_tdata[63:32], 32'h0);
      chk("wr0_unchanged", wr_tdata[31:0], 32'hDEAD1234);

      rd_tvalid[0] = 1'b1;
      rd_tdata[31:0] = 32'h000055AA;
      axi_read(8'h14, 32'h000055AA, OK, 0);
      rd_tvalid[0] = 1'b0;
      axi_read(8'h14, 32'h0, SE, -1);
      rd_tvalid[3] = 1'b1;
      rd_tdata[127:96] = 32'hA5A50003;
      axi_read(8'h20, 32'hA5A50003, OK, 3);
      rd_tvalid[3] = 1'b0;

      wr_tready = 4'b1101;
      rd_tvalid = 4'b0010;
      axi_read(8'h00, 32'h0000002D, OK, -1);
      rd_tvalid = '0;
      wr_tready = '1;
      axi_read(8'h04, 32'h0, SE, -1);
      axi_read(8'h24, 32'h0, SE, -1);

      // Park the write path in W_NEED_W and the read path in R_DATA
      s_awaddr = 8'h04;
      s_awvalid = 1'b1;
      @(posedge clk); #1;
      s_awvalid = 1'b0;
      s_rready = 1'b0;
      s_araddr = 8'h00;
      s_arvalid = 1'b1;
      @(posedge clk); #1;
      s_arvalid = 1'b0;
      chk("pre_rst_state", {s_awready, s_wready, s_rvalid}, 3'b011);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_valid", {s_bvalid, s_rvalid}, 2'b00);
      chk("mid_rst_ready", {s_awready, s_wready, s_arready}, 3'b111);
      @(posedge clk); #1;
      reset = 1'b0;
      s_rready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("post_rst_ready", {s_awready, s_wready, s_arready}, 3'b111);
      chk("post_rst_shadow", wr_tdata, '0);

      axi_write(8'h10, 32'h0BADF00D, 4'h9, OK, 3, 32'h0B00000D, 0, 0);
      repeat (3) @(posedge clk);
      #1;

      chk("exp_b_left", exp_b.size(), 0);
      chk("exp_r_left", exp_r.size(), 0);
      chk("exp_wr_left", exp_wr.size(), 0);
      chk("exp_pop_left", exp_pop.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
